oled_frame_refresh: RTL and testbench



---
 rtl/oled_pkg.sv | 19 +
 rtl/oled_spi_byte.sv | 62 ++++++
 rtl/oled_frame_refresh.sv | 128 ++++++++++++
 tb/tb_oled_frame_refresh.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oled_pkg.sv
// Shared constants and FSM state type for the OLED frame refresh path.
package oled_pkg;

  localparam int unsigned OLED_PAGES      = 8;
  localparam int unsigned OLED_COLS       = 128;
  localparam int unsigned OLED_RAM_RD_LAT = 2;

  localparam logic [7:0] CMD_PAGE_BASE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO    = 8'h00;
  localparam logic [7:0] CMD_COL_HI    = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } oled_state_t;

endpackage

// File: rtl/oled_spi_byte.sv
// SPI mode-0 byte shifter: one load cycle, then 16*CLK_DIV shift cycles, MSB first.
module oled_spi_byte #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic       active;
  logic [7:0] half_cnt;
  logic [3:0] phase;
  logic [7:0] shreg;
  logic       half_end;

  assign half_end  = active && (half_cnt == HALF_LAST);
  // Asserted in the final shift cycle so the next load lands right after it.
  assign byte_done = half_end && (phase == 4'd15);
  assign mosi      = shreg[7];

  // Half-period divider, SCLK toggling and shift on each falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      half_cnt <= '0;
      phase    <= '0;
      shreg    <= '0;
      sclk     <= 1'b0;
    end else if (load) begin
      active   <= 1'b1;
      half_cnt <= '0;
      phase    <= '0;
      shreg    <= byte_in;
      sclk     <= 1'b0;
    end else if (active) begin
      if (half_end) begin
        half_cnt <= '0;
        phase    <= phase + 4'd1;
        if (!phase[0]) begin
          sclk <= 1'b1;
        end else begin
          sclk <= 1'b0;
          // Last bit is held on MOSI until the next load.
          if (phase == 4'd15) begin
            active <= 1'b0;
          end else begin
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end else begin
        half_cnt <= half_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/oled_frame_refresh.sv
// Streams the 8x128 OLED frame RAM to an SSD1306-class panel over 4-wire SPI.
module oled_frame_refresh
  import oled_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [9:0] rdaddress,
  input  logic [7:0] rddata,
  output logic       oled_cs,
  output logic       oled_dc,
  output logic       oled_sclk,
  output logic       oled_mosi
);

  localparam logic [2:0] PAGE_LAST = 3'(OLED_PAGES - 1);
  localparam logic [6:0] COL_LAST  = 7'(OLED_COLS - 1);

  oled_state_t state;
  logic [2:0]  page;
  logic [6:0]  col;
  logic [1:0]  cmd_idx;
  logic        load;
  logic [7:0]  tx_byte;
  logic        byte_done;

  // Byte presented to the shifter during the load cycle.
  always_comb begin
    tx_byte = rddata;
    if (state == ST_CMD) begin
      case (cmd_idx)
        2'd0:    tx_byte = CMD_PAGE_BASE | {5'b0, page};
        2'd1:    tx_byte = CMD_COL_LO;
        default: tx_byte = CMD_COL_HI;
      endcase
    end
  end

  oled_spi_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .byte_in   (tx_byte),
    .sclk      (oled_sclk),
    .mosi      (oled_mosi),
    .byte_done (byte_done)
  );

  // Frame sequencing: page commands, data bytes, RAM prefetch and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      page      <= '0;
      col       <= '0;
      cmd_idx   <= '0;
      load      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      oled_cs   <= 1'b1;
      oled_dc   <= 1'b0;
      rdaddress <= '0;
    end else begin
      load <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_CMD;
            page    <= '0;
            cmd_idx <= '0;
            oled_dc <= 1'b0;
            oled_cs <= 1'b0;
            busy    <= 1'b1;
            load    <= 1'b1;
          end
        end
        ST_CMD: begin
          if (byte_done) begin
            load <= 1'b1;
            if (cmd_idx == 2'd2) begin
              state   <= ST_DATA;
              col     <= '0;
              oled_dc <= 1'b1;
            end else begin
              cmd_idx <= cmd_idx + 2'd1;
              // Address of data byte 0 goes out with the third command byte.
              if (cmd_idx == 2'd1) rdaddress <= {page, 7'd0};
            end
          end
        end
        ST_DATA: begin
          // Prefetch the next column while the current byte shifts out.
          if (load) rdaddress <= {page, col + 7'd1};
          if (byte_done) begin
            if (col == COL_LAST) begin
              if (page == PAGE_LAST) begin
                state   <= ST_DONE;
                busy    <= 1'b0;
                oled_cs <= 1'b1;
              end else begin
                state   <= ST_CMD;
                page    <= page + 3'd1;
                cmd_idx <= '0;
                oled_dc <= 1'b0;
                load    <= 1'b1;
              end
            end else begin
              col  <= col + 7'd1;
              load <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          done    <= 1'b1;
          oled_dc <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_refresh.sv
// Bench for oled_frame_refresh: scoreboarded SPI capture (CLK_DIV=2) and mode-0 timing (CLK_DIV=5).
module tb_oled_frame_refresh;

  localparam int unsigned FRAME_BYTES = 1048;
  localparam int unsigned DONE_LAT_A  = 34586;  // 1048*(16*2+1)+2
  localparam int unsigned SLOT_B      = 81;     // 16*5+1
  localparam int unsigned ABORT_BYTES = 436;    // 3 pages * 131 + 3 cmd + 40 data

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A, CLK_DIV = 2
  logic       rst = 1'b1, start = 1'b0;
  logic       busy, done, oled_cs, oled_dc, oled_sclk, oled_mosi;
  logic [9:0] rdaddress;
  logic [7:0] rddata = '0;
  logic [9:0] addr_q = '0;

  // DUT B, CLK_DIV = 5
  logic       rst5 = 1'b1, start5 = 1'b0;
  logic       busy5, done5, cs5, dc5, sclk5, mosi5;
  logic [9:0] rdaddr5;
  logic [7:0] rddata5 = '0;
  logic [9:0] addr5_q = '0;

  oled_frame_refresh #(.CLK_DIV(2)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rdaddress(rdaddress), .rddata(rddata), .oled_cs(oled_cs), .oled_dc(oled_dc),
    .oled_sclk(oled_sclk), .oled_mosi(oled_mosi)
  );

  oled_frame_refresh #(.CLK_DIV(5)) dut5 (
    .clk(clk), .rst(rst5), .start(start5), .busy(busy5), .done(done5),
    .rdaddress(rdaddr5), .rddata(rddata5), .oled_cs(cs5), .oled_dc(dc5),
    .oled_sclk(sclk5), .oled_mosi(mosi5)
  );

  function automatic logic [7:0] ram_val(input logic [9:0] a);
    return a[7:0] ^ {5'b0, a[9:7]};
  endfunction

  // Frame RAM models: registered address, registered data.
  always @(posedge clk) begin
    addr_q  <= rdaddress;
    rddata  <= ram_val(addr_q);
    addr5_q <= rdaddr5;
    rddata5 <= ram_val(addr5_q);
  end

  int unsigned checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard state
  logic [8:0]  exp_q[$];
  int unsigned exp_done_q[$];
  logic [8:0]  cap_q[$];
  logic [8:0]  capB[$];
  int unsigned ncap = 0, ndone = 0;

  task automatic push_frame();
    for (int unsigned p = 0; p < 8; p++) begin
      exp_q.push_back({1'b0, 8'hB0 | 8'(p)});
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h10});
      for (int unsigned c = 0; c < 128; c++)
        exp_q.push_back({1'b1, ram_val(10'(p * 128 + c))});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cs"},   oled_cs,   1'b1);
    check({tag, "_sclk"}, oled_sclk, 1'b0);
    check({tag, "_mosi"}, oled_mosi, 1'b0);
    check({tag, "_dc"},   oled_dc,   1'b0);
    check({tag, "_busy"}, busy,      1'b0);
    check({tag, "_done"}, done,      1'b0);
    check({tag, "_addr"}, rdaddress, 10'd0);
  endtask

  task automatic start_frame(output int unsigned t);
    @(negedge clk);
    start = 1'b1;
    t = cyc;
    push_frame();
    exp_done_q.push_back(t + DONE_LAT_A);
    @(negedge clk);
    start = 1'b0;
    check("cs_fall", oled_cs, 1'b0);
    check("busy_rise", busy, 1'b1);
  endtask

  task automatic wait_done(input int unsigned limit, input string name);
    int unsigned n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, limit);
    end
  endtask

  // Monitor A: SPI slave capture plus done-time scoreboard.
  initial begin
    int unsigned bitcnt = 0;
    logic [7:0]  sh = '0;
    logic        sclk_prev = 1'b0;
    logic [8:0]  got;
    forever begin
      @(negedge clk);
      if (rst) begin
        bitcnt = 0;
        sclk_prev = 1'b0;
      end else begin
        if (oled_cs) begin
          bitcnt = 0;
        end else if (oled_sclk && !sclk_prev) begin
          sh = {sh[6:0], oled_mosi};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            got = {oled_dc, sh};
            cap_q.push_back(got);
            ncap++;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL spi_byte: unexpected byte 0x%0h, none required", got);
            end else begin
              check("spi_byte", got, exp_q.pop_front());
            end
          end
        end
        sclk_prev = oled_sclk;
        if (done) begin
          ndone++;
          if (exp_done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_pulse: unexpected done at cycle %0d, none required", cyc);
          end else begin
            check("done_cycle", cyc, exp_done_q.pop_front());
          end
        end
      end
    end
  end

  // Monitor B: mode-0 timing, dc stability and slot length at CLK_DIV=5.
  int unsigned nbyte5 = 0;
  initial begin
    int unsigned bitcnt = 0, first_rise = 0;
    bit          have_first = 1'b0;
    logic [7:0]  sh = '0;
    logic        sclk_prev = 1'b0, mosi_prev = 1'b0, dc_first = 1'b0;
    forever begin
      @(negedge clk);
      if (rst5) begin
        bitcnt = 0;
        have_first = 1'b0;
        sclk_prev = 1'b0;
        mosi_prev = 1'b0;
      end else begin
        if (sclk5) check("mosi_stable_sclk_high", mosi5, mosi_prev);
        if (cs5) begin
          bitcnt = 0;
        end else if (sclk5 && !sclk_prev) begin
          if (bitcnt == 0) begin
            if (have_first) check("slot_len", cyc - first_rise, SLOT_B);
            first_rise = cyc;
            have_first = 1'b1;
            dc_first = dc5;
          end else begin
            check("dc_stable_in_slot", dc5, dc_first);
          end
          sh = {sh[6:0], mosi5};
          bitcnt++;
          if (bitcnt == 8) begin
            bitcnt = 0;
            nbyte5++;
            if (nbyte5 == 1) check("div5_first_byte", {dc5, sh}, {1'b0, 8'hB0});
          end
        end
        sclk_prev = sclk5;
        mosi_prev = mosi5;
      end
    end
  end

  // Stimulus B: one partial frame at CLK_DIV=5, abandoned after 200 bytes.
  bit b_finished = 1'b0;
  initial begin
    int unsigned n = 0;
    repeat (3) @(negedge clk);
    rst5 = 1'b0;
    repeat (2) @(negedge clk);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    check("div5_busy", busy5, 1'b1);
    while (nbyte5 < 200 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("div5_bytes_seen", (nbyte5 >= 200), 1'b1);
    check("div5_no_early_done", done5, 1'b0);
    rst5 = 1'b1;
    b_finished = 1'b1;
  end

  // Watchdog
  initial begin
    #(10 * 98000);
    errors++;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Main stimulus
  initial begin
    int unsigned t_a, t_b, t_c, n, mism;
    logic [15:0] outs;
    int unsigned offs[3] = '{10, 500, 20000};

    // Reset held for 3 cycles, then idle with start low.
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    for (int unsigned i = 0; i < 100; i++) begin
      @(negedge clk);
      outs = {busy, done, oled_cs, oled_dc, oled_sclk, oled_mosi, rdaddress};
      check("idle_outputs", outs, {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
    end

    // Frame A: abort with rst during page 3, data byte 40.
    start_frame(t_a);
    n = 0;
    while (ncap < ABORT_BYTES && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("abort_point_reached", ncap, ABORT_BYTES);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    exp_q.delete();
    exp_done_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("after_abort");

    // Frame B: clean frame; extra start pulses while busy are ignored.
    cap_q.delete();
    ndone = 0;
    start_frame(t_b);
    for (int unsigned k = 0; k < 3; k++) begin
      while (cyc < t_b + offs[k]) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(DONE_LAT_A + 100, "frame_b_done");

    // Frame C: start in the cycle after done.
    @(negedge clk);
    check("frame_b_done_count", ndone, 1);
    check("frame_b_bytes", cap_q.size(), FRAME_BYTES);
    check("frame_b_sb_empty", exp_q.size(), 0);
    capB = cap_q;
    cap_q.delete();
    start = 1'b1;
    t_c = cyc;
    push_frame();
    exp_done_q.push_back(t_c + DONE_LAT_A);
    @(negedge clk);
    start = 1'b0;
    check("frame_c_cs_fall", oled_cs, 1'b0);

    if (capB.size() == FRAME_BYTES) begin
      check("b_byte0",    capB[0],    {1'b0, 8'hB0});
      check("b_byte1",    capB[1],    {1'b0, 8'h00});
      check("b_byte2",    capB[2],    {1'b0, 8'h10});
      check("b_byte3",    capB[3],    {1'b1, 8'h00});
      check("b_byte131",  capB[131],  {1'b0, 8'hB1});
      check("b_byte134",  capB[134],  {1'b1, 8'h81});
      check("b_byte1047", capB[1047], {1'b1, 8'hF8});
    end

    wait_done(DONE_LAT_A + 100, "frame_c_done");
    @(negedge clk);
    check("frame_c_done_count", ndone, 2);
    check("frame_c_bytes", cap_q.size(), FRAME_BYTES);
    mism = 0;
    for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
      if (i >= cap_q.size() || i >= capB.size()) mism++;
      else if (cap_q[i] !== capB[i]) mism++;
    end
    check("frames_identical_mismatches", mism, 0);
    check("idle_after_frames_cs", oled_cs, 1'b1);

    n = 0;
    while (!b_finished && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("div5_run_finished", b_finished, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
